// File: rtl/snes_pad_scanner.sv
// SNES pad scanner: polls five serial SNES pads over a shared LATCH/CLK pair,
// remaps each 16-bit report onto the 12 Mega Drive button lines and presents
// active-low per-pad vectors for the multitap's P1..P5 button inputs.
module snes_pad_scanner #(
    parameter int HALF_PERIOD = 256,
    parameter int POLL_PERIOD = 894886,
    parameter bit DEBOUNCE    = 1'b1
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        ENABLE,
    input  logic        FORCE,
    input  logic [4:0]  PAD_DATA,
    output logic        PAD_LATCH,
    output logic        PAD_CLK,
    output logic [11:0] P1_BTN,
    output logic [11:0] P2_BTN,
    output logic [11:0] P3_BTN,
    output logic [11:0] P4_BTN,
    output logic [11:0] P5_BTN,
    output logic        BUSY,
    output logic        FRAME
);

    localparam int HW = $clog2(2 * HALF_PERIOD);
    localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;

    localparam logic [HW-1:0] HALF_LAST  = HW'(HALF_PERIOD - 1);
    localparam logic [HW-1:0] LATCH_LAST = HW'(2 * HALF_PERIOD - 1);
    localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_PERIOD - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LATCH  = 2'd1;
    localparam logic [1:0] S_SHIFT  = 2'd2;
    localparam logic [1:0] S_COMMIT = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [HW-1:0]     tmr_q, tmr_d;
    logic              phase_q, phase_d;      // 0 = PAD_CLK high half, 1 = low half
    logic [3:0]        bit_q, bit_d;
    logic [PW-1:0]     poll_q, poll_d;
    logic              pending_q, pending_d;
    logic [4:0]        sync1_q, sync2_q;
    logic [4:0][15:0]  word_q;
    logic [4:0][15:0]  prev_q;
    logic [4:0][11:0]  btn_q;
    logic              frame_q;
    logic              commit;
    logic              sample;
    logic              poll_wrap;
    logic [4:0]        load;

    // SNES word -> {Z,Y,X,MODE,START,C,B,A,RIGHT,LEFT,DOWN,UP}; both sides active-low
    function automatic logic [11:0] map_md(input logic [15:0] w);
        return {w[11], w[9], w[10], w[2], w[3], w[8], w[0], w[1], w[7], w[6], w[5], w[4]};
    endfunction

    // Two-flop synchroniser on each pad data pin; idles at the pulled-up level
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= PAD_DATA;
            sync2_q <= sync1_q;
        end
    end

    assign poll_wrap = ENABLE && (poll_q == POLL_LAST);
    assign sample    = (state_q == S_SHIFT) && !phase_q && (tmr_q == HALF_LAST);

    // Scan sequencer, poll timer and the single-entry scan request
    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        pending_d = pending_q;
        commit    = 1'b0;
        poll_d    = poll_wrap ? '0 : poll_q + PW'(1);

        if (state_q == S_IDLE && FORCE) pending_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (pending_q) begin
                    state_d   = S_LATCH;
                    tmr_d     = '0;
                    pending_d = 1'b0;
                end
            end
            S_LATCH: begin
                if (tmr_q == LATCH_LAST) begin
                    state_d = S_SHIFT;
                    tmr_d   = '0;
                    phase_d = 1'b0;
                    bit_d   = 4'd0;
                end else begin
                    tmr_d = tmr_q + HW'(1);
                end
            end
            S_SHIFT: begin
                if (tmr_q == HALF_LAST) begin
                    tmr_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (bit_q == 4'd15) state_d = S_COMMIT;
                        else                bit_d   = bit_q + 4'd1;
                    end
                end else begin
                    tmr_d = tmr_q + HW'(1);
                end
            end
            default: begin
                commit  = 1'b1;
                state_d = S_IDLE;
            end
        endcase

        // A wrap that lands while a request is being consumed starts the next scan
        if (poll_wrap) pending_d = 1'b1;

        // Disabling abandons any scan in flight and restarts the poll interval
        if (!ENABLE) begin
            state_d   = S_IDLE;
            pending_d = 1'b0;
            poll_d    = '0;
            commit    = 1'b0;
        end
    end

    // Control state registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= S_IDLE;
            tmr_q     <= '0;
            phase_q   <= 1'b0;
            bit_q     <= 4'd0;
            poll_q    <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            poll_q    <= poll_d;
            pending_q <= pending_d;
        end
    end

    // Capture bit i of every pad on the last cycle of the PAD_CLK-high half
    always_ff @(posedge CLK) begin
        if (sample) begin
            for (int p = 0; p < 5; p++) word_q[p][bit_q] <= sync2_q[p];
        end
    end

    // A pad loads when debounce is off or its word repeats the previous scan
    always_comb begin
        load = '0;
        for (int p = 0; p < 5; p++) begin
            load[p] = commit && (!DEBOUNCE || (word_q[p] == prev_q[p]));
        end
    end

    // Button vectors, previous-scan words and the FRAME strobe
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            btn_q   <= {5{12'hFFF}};
            prev_q  <= {5{16'hFFFF}};
            frame_q <= 1'b0;
        end else begin
            frame_q <= |load;
            for (int p = 0; p < 5; p++) begin
                if (commit)  prev_q[p] <= word_q[p];
                if (load[p]) btn_q[p]  <= map_md(word_q[p]);
            end
        end
    end

    assign PAD_LATCH = (state_q == S_LATCH);
    assign PAD_CLK   = !((state_q == S_SHIFT) && phase_q);
    assign BUSY      = (state_q != S_IDLE);
    assign FRAME     = frame_q;
    assign P1_BTN    = btn_q[0];
    assign P2_BTN    = btn_q[1];
    assign P3_BTN    = btn_q[2];
    assign P4_BTN    = btn_q[3];
    assign P5_BTN    = btn_q[4];

endmodule

// File: tb/tb_snes_pad_scanner.sv
// Bench for snes_pad_scanner: two instances (debounce off / on) share one set
// of serial pad models; a scan-level model predicts buttons and FRAME.
module tb_snes_pad_scanner;

    localparam int H    = 4;
    localparam int PP   = 200;
    localparam int SCAN = 2 * H + 32 * H + 1;
    // SNES word bit feeding each MD line, MD bit 0 (UP) first
    localparam int SRC [12] = '{4, 5, 6, 7, 1, 0, 8, 3, 2, 10, 9, 11};

    logic        CLK = 1'b0;
    logic        RESET_N, ENABLE, FORCE;
    logic [4:0]  pad_data;
    logic [1:0]  pad_latch, pad_clk, busy, frame;
    logic [11:0] btn [2][5];

    always #5 CLK = ~CLK;

    snes_pad_scanner #(.HALF_PERIOD(H), .POLL_PERIOD(PP), .DEBOUNCE(1'b0)) dut0 (
        .CLK(CLK), .RESET_N(RESET_N), .ENABLE(ENABLE), .FORCE(FORCE),
        .PAD_DATA(pad_data), .PAD_LATCH(pad_latch[0]), .PAD_CLK(pad_clk[0]),
        .P1_BTN(btn[0][0]), .P2_BTN(btn[0][1]), .P3_BTN(btn[0][2]),
        .P4_BTN(btn[0][3]), .P5_BTN(btn[0][4]), .BUSY(busy[0]), .FRAME(frame[0])
    );

    snes_pad_scanner #(.HALF_PERIOD(H), .POLL_PERIOD(PP), .DEBOUNCE(1'b1)) dut1 (
        .CLK(CLK), .RESET_N(RESET_N), .ENABLE(ENABLE), .FORCE(FORCE),
        .PAD_DATA(pad_data), .PAD_LATCH(pad_latch[1]), .PAD_CLK(pad_clk[1]),
        .P1_BTN(btn[1][0]), .P2_BTN(btn[1][1]), .P3_BTN(btn[1][2]),
        .P4_BTN(btn[1][3]), .P5_BTN(btn[1][4]), .BUSY(busy[1]), .FRAME(frame[1])
    );

    // Pad model: word captured while LATCH is high, shifts on each PAD_CLK rise
    logic [15:0] pad_word   [5];
    logic [15:0] pad_shadow [5] = '{default: 16'hFFFF};
    logic [4:0]  bitpos   = 5'd0;
    logic        clk_prev = 1'b1;

    always @(posedge CLK) begin
        clk_prev <= pad_clk[0];
        if (pad_latch[0]) begin
            bitpos <= 5'd0;
            for (int p = 0; p < 5; p++) pad_shadow[p] <= pad_word[p];
        end else if (pad_clk[0] && !clk_prev && bitpos != 5'd16) begin
            bitpos <= bitpos + 5'd1;
        end
    end

    always_comb begin
        pad_data = '1;
        for (int p = 0; p < 5; p++) pad_data[p] = bitpos[4] ? 1'b1 : pad_shadow[p][bitpos[3:0]];
    end

    // Scan-level reference model
    logic [15:0] prev_m [2][5];
    logic [11:0] btn_m  [2][5];
    int nassert = 0;
    int nfail   = 0;

    function automatic logic [11:0] map_word(input logic [15:0] w);
        logic [11:0] m;
        for (int b = 0; b < 12; b++) m[b] = w[SRC[b]];
        return m;
    endfunction

    function automatic logic [59:0] dut_vec(input int d);
        return {btn[d][4], btn[d][3], btn[d][2], btn[d][1], btn[d][0]};
    endfunction

    function automatic logic [59:0] model_vec(input int d);
        return {btn_m[d][4], btn_m[d][3], btn_m[d][2], btn_m[d][1], btn_m[d][0]};
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 5; p++) begin
                prev_m[d][p] = 16'hFFFF;
                btn_m[d][p]  = 12'hFFF;
            end
    endtask

    task automatic model_commit(output logic [1:0] fr);
        fr = 2'b00;
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 5; p++) begin
                if (d == 0 || pad_word[p] == prev_m[d][p]) begin
                    btn_m[d][p] = map_word(pad_word[p]);
                    fr[d] = 1'b1;
                end
                prev_m[d][p] = pad_word[p];
            end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nassert++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_watch(input int cycles, output int hits);
        hits = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge CLK);
            if (pad_latch !== 2'b00 || frame !== 2'b00 || busy !== 2'b00) hits++;
        end
    endtask

    // Wait for a scan (latency lo..hi cycles), check its waveform and result
    task automatic run_scan(input string tag, input int lo, input int hi, input int rel_k);
        int n = 0;
        int bad = 0;
        logic exp_l, exp_c;
        logic [1:0] fr;
        while (pad_latch[0] !== 1'b1 && n < hi + 5) begin
            @(negedge CLK);
            n++;
        end
        nassert++;
        assert (n >= lo && n <= hi) else begin
            nfail++;
            $error("FAIL %s latency: observed %0d expected %0d..%0d", tag, n, lo, hi);
        end
        if (pad_latch[0] !== 1'b1) return;
        for (int k = 0; k < SCAN; k++) begin
            if (k == rel_k) FORCE = 1'b0;
            exp_l = (k < 2 * H);
            exp_c = (k < 2 * H || k == SCAN - 1) ? 1'b1 : (((k - 2 * H) / H) % 2 == 0);
            for (int d = 0; d < 2; d++)
                if (pad_latch[d] !== exp_l || pad_clk[d] !== exp_c ||
                    busy[d] !== 1'b1 || frame[d] !== 1'b0) bad++;
            @(negedge CLK);
        end
        chk({tag, " wave"}, bad, 0);
        model_commit(fr);
        chk({tag, " frame"}, frame, fr);
        chk({tag, " busy"}, busy, 2'b00);
        chk({tag, " btn0"}, dut_vec(0), model_vec(0));
        chk({tag, " btn1"}, dut_vec(1), model_vec(1));
    endtask

    initial begin
        int hits;
        int n;
        RESET_N = 1'b0;
        ENABLE  = 1'b0;
        FORCE   = 1'b0;
        for (int p = 0; p < 5; p++) pad_word[p] = 16'hFFFF;
        model_reset();
        repeat (3) @(negedge CLK);

        // reset state
        chk("rst latch", pad_latch, 2'b00);
        chk("rst pclk", pad_clk, 2'b11);
        chk("rst busy", busy, 2'b00);
        chk("rst frame", frame, 2'b00);
        chk("rst btn0", dut_vec(0), {5{12'hFFF}});
        chk("rst btn1", dut_vec(1), {5{12'hFFF}});
        RESET_N = 1'b1;

        // disabled: no polling at all
        idle_watch(300, hits);
        chk("disabled idle", hits, 0);

        // forced scan, pad1 reports B
        pad_word[0] = 16'hFFFE;
        ENABLE = 1'b1;
        FORCE  = 1'b1;
        @(negedge CLK);
        FORCE = 1'b0;
        run_scan("t1 force", 1, 2, -1);
        chk("t1 p1 nodeb", btn[0][0], 12'hFDF);
        chk("t1 p2 nodeb", btn[0][1], 12'hFFF);
        run_scan("t1 poll", 0, PP, -1);
        chk("t1 p1 deb", btn[1][0], 12'hFDF);

        // debounce on pad3
        pad_word[2] = 16'hFFEF; run_scan("t2 s1", 0, PP, -1); chk("t2 p3 s1", btn[1][2], 12'hFFF);
        pad_word[2] = 16'hFFFF; run_scan("t2 s2", 0, PP, -1); chk("t2 p3 s2", btn[1][2], 12'hFFF);
        pad_word[2] = 16'hFFFF; run_scan("t2 s3", 0, PP, -1); chk("t2 p3 s3", btn[1][2], 12'hFFF);
        pad_word[2] = 16'hFFEF; run_scan("t2 s4", 0, PP, -1); chk("t2 p3 s4", btn[1][2], 12'hFFF);
        pad_word[2] = 16'hFFEF; run_scan("t2 s5", 0, PP, -1); chk("t2 p3 s5", btn[1][2], 12'hFFE);

        // single-bit walk on pad5 covers the whole mapping
        for (int b = 0; b < 16; b++) begin
            pad_word[4] = ~(16'h0001 << b);
            run_scan($sformatf("t3 bit%0d", b), 0, PP, -1);
        end
        pad_word[4] = 16'hFFFF;
        run_scan("t3 clear", 0, PP, -1);

        // random reports, sometimes repeating so debounce accepts them
        for (int i = 0; i < 6; i++) begin
            for (int p = 0; p < 5; p++)
                if ($urandom_range(0, 1) == 1) pad_word[p] = 16'($urandom);
            run_scan($sformatf("rnd%0d", i), 0, PP, -1);
        end

        // FORCE held through a scan; a poll wrap inside it queues one scan
        ENABLE = 1'b0;
        repeat (2) @(negedge CLK);
        ENABLE = 1'b1;
        repeat (100) @(negedge CLK);
        FORCE = 1'b1;
        run_scan("t4 force", 1, 2, 120);
        run_scan("t4 wrap", 1, 1, -1);
        idle_watch(20, hits);
        chk("t4 no extra", hits, 0);

        // abort mid-shift keeps the buttons
        pad_word[0] = 16'hFFFE;
        run_scan("t5 a", 0, PP, -1);
        run_scan("t5 b", 0, PP, -1);
        chk("t5 p1 pre", {btn[1][0], btn[0][0]}, {12'hFDF, 12'hFDF});
        pad_word[0] = 16'h0000;
        pad_word[1] = 16'($urandom);
        n = 0;
        while (pad_latch[0] !== 1'b1 && n < PP + 5) begin
            @(negedge CLK);
            n++;
        end
        chk("t5 latch seen", pad_latch, 2'b11);
        repeat (2 * H + 7 * 2 * H + H + 1) @(negedge CLK);
        chk("t5 bit7 low", pad_clk, 2'b00);
        ENABLE = 1'b0;
        @(negedge CLK);
        chk("t5 abort pclk", pad_clk, 2'b11);
        chk("t5 abort latch", pad_latch, 2'b00);
        chk("t5 abort busy", busy, 2'b00);
        chk("t5 abort p1", {btn[1][0], btn[0][0]}, {12'hFDF, 12'hFDF});
        idle_watch(300, hits);
        chk("t5 quiet", hits, 0);
        chk("t5 hold btn0", dut_vec(0), model_vec(0));
        chk("t5 hold btn1", dut_vec(1), model_vec(1));
        pad_word[0] = 16'hFFFE;
        ENABLE = 1'b1;
        run_scan("t5 reenable", PP, PP + 2, -1);

        // asynchronous reset mid-latch
        n = 0;
        while (pad_latch[0] !== 1'b1 && n < PP + 5) begin
            @(negedge CLK);
            n++;
        end
        repeat (3) @(negedge CLK);
        #1 RESET_N = 1'b0;
        #1;
        chk("t6 latch", pad_latch, 2'b00);
        chk("t6 pclk", pad_clk, 2'b11);
        chk("t6 busy", busy, 2'b00);
        chk("t6 btn0", dut_vec(0), {5{12'hFFF}});
        chk("t6 btn1", dut_vec(1), {5{12'hFFF}});
        model_reset();
        @(negedge CLK);
        RESET_N = 1'b1;
        run_scan("t6 after reset", PP, PP + 2, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule
